// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to packed-BCD converter using shift-and-add-3, one bit per clock.
// Optional feature: define BIN2BCD_CLAMP_EN to saturate bcd at 16'h9999 when the operand exceeds 9999.
module bin2bcd_seq #(
  parameter int BIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int             CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Add 3 to every accumulator digit that is 5 or more; result never exceeds 4'hC.
  function automatic logic [19:0] add3_digits(input logic [19:0] acc);
    logic [19:0] res;
    res = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BIN_W-1:0]   bin_r, bin_s;
  logic [19:0]        acc_r, acc_s;
  logic [15:0]        bcd_r, bcd_s;
  logic               ovf_r, ovf_s;
  logic               busy_r, done_r;
  logic [19:0]        corr_s;
  logic [19:0]        acc_shift_s;
  logic [BIN_W-1:0]   bin_shift_s;
  logic               ovf_final_s;
  logic [15:0]        bcd_final_s;
  logic               load_s;

  assign corr_s      = add3_digits(acc_r);
  assign acc_shift_s = {corr_s[18:0], bin_r[BIN_W-1]};
  assign bin_shift_s = {bin_r[BIN_W-2:0], 1'b0};
  assign ovf_final_s = |acc_shift_s[19:16];

`ifdef BIN2BCD_CLAMP_EN
  assign bcd_final_s = ovf_final_s ? 16'h9999 : acc_shift_s[15:0];
`else
  assign bcd_final_s = acc_shift_s[15:0];
`endif

  // Next-state and datapath update; start is only honoured outside SHIFT.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bin_s   = bin_r;
    acc_s   = acc_r;
    bcd_s   = bcd_r;
    ovf_s   = ovf_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        acc_s = acc_shift_s;
        bin_s = bin_shift_s;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
          bcd_s   = bcd_final_s;
          ovf_s   = ovf_final_s;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (load_s) begin
      state_s = SHIFT;
      bin_s   = bin;
      acc_s   = 20'h00000;
      cnt_s   = CNT_LOAD;
    end else begin
      load_s  = 1'b0;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bin_r   <= '0;
      acc_r   <= 20'h00000;
      bcd_r   <= 16'h0000;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bin_r   <= bin_s;
      acc_r   <= acc_s;
      bcd_r   <= bcd_s;
      ovf_r   <= ovf_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;
  assign ovf  = ovf_r;

endmodule
